// File: rtl/sdram_resp_pkg.sv
// sdram_resp_pkg: command codes, bank states, mode fields and err bits
// shared by the SDRAM responder and its bank trackers.
package sdram_resp_pkg;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BST   = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  typedef enum logic {
    IDLE,
    OPEN
  } bank_state_t;

  localparam int MODE_CL_HI = 6;
  localparam int MODE_CL_LO = 4;
  localparam int MODE_BL_HI = 2;
  localparam int MODE_BL_LO = 0;
  localparam int MODE_WB    = 9;

  localparam int ERR_TRCD   = 0;
  localparam int ERR_BANK   = 1;
  localparam int ERR_MODE   = 2;
  localparam int ERR_NOMODE = 3;

endpackage

// File: rtl/sdram_resp_bank.sv
// sdram_resp_bank: one bank's IDLE/OPEN tracker and open-row register.
// SDRAM_RESP_CHECK_EN adds the tRCD down-counter and early flag.
module sdram_resp_bank
  import sdram_resp_pkg::*;
#(
  parameter int ROW_AW = 4,
  parameter int TRCD   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              act,
  input  logic              pre,
  input  logic              acc,
  input  logic              auto_pre,
  input  logic [ROW_AW-1:0] row_in,
  output logic              opened,
  output logic [ROW_AW-1:0] row
`ifdef SDRAM_RESP_CHECK_EN
  ,
  output logic              early
`endif
);

  bank_state_t state, state_nx;

  // bank state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // open on ACTIVE, close on precharge or auto-precharge access
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (act) state_nx = OPEN;
      OPEN: if (pre || (acc && auto_pre)) state_nx = IDLE;
    endcase
  end

  assign opened = (state == OPEN);

  // row latched only when ACTIVE really opens the bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 row <= '0;
    else if (act && state == IDLE) row <= row_in;
  end

`ifdef SDRAM_RESP_CHECK_EN
  localparam logic [3:0] TRCD_LD = 4'((TRCD > 0) ? TRCD - 1 : 0);

  logic [3:0] cnt;

  // cycles still to wait before a column access is on time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cnt <= '0;
    else if (act && state == IDLE) cnt <= TRCD_LD;
    else if (cnt != 4'd0)          cnt <= cnt - 4'd1;
  end

  assign early = (cnt != 4'd0);
`endif

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: chip-side SDR SDRAM model serving a BRAM.
// SDRAM_RESP_CHECK_EN builds tRCD counters and the sticky err flags.
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter  int ROW_AW = 4,
  parameter  int TRCD   = 2,
  localparam int MEM_AW = 2 + ROW_AW + 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        mode_ok,
  output logic [15:0] refresh_cnt,
  output logic [3:0]  err
);

  logic [3:0] cmd;
  logic is_act, is_rd, is_wr, is_bst;
  logic is_pre, is_ref, is_lmr;

  assign cmd    = {sd_cs, sd_ras, sd_cas, sd_we};
  assign is_act = (cmd == CMD_ACT);
  assign is_rd  = (cmd == CMD_READ);
  assign is_wr  = (cmd == CMD_WRITE);
  assign is_bst = (cmd == CMD_BST);
  assign is_pre = (cmd == CMD_PRE);
  assign is_ref = (cmd == CMD_REF);
  assign is_lmr = (cmd == CMD_LMR);

  logic [3:0]        opened;
  logic [3:0]        sel;
  logic [ROW_AW-1:0] row [4];
  logic all_idle, sel_open, acc_ok;
  logic mode_vld, cl3, cancel;
  logic unused_addr;

  assign sel      = 4'b0001 << sd_ba;
  assign all_idle = (opened == 4'b0000);
  assign sel_open = opened[sd_ba];
  assign acc_ok   = (is_rd | is_wr) & sel_open & mode_ok;
  assign cancel   = is_wr | is_bst;
  assign unused_addr = ^{sd_addr[12:11], sd_addr[8]};

  assign mode_vld =
    (sd_addr[MODE_CL_HI:MODE_CL_LO] == 3'd2 ||
     sd_addr[MODE_CL_HI:MODE_CL_LO] == 3'd3) &&
    sd_addr[MODE_BL_HI:MODE_BL_LO] == 3'b000 &&
    sd_addr[MODE_WB];

`ifdef SDRAM_RESP_CHECK_EN
  logic [3:0] early;
  logic [3:0] err_set;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_bank
    sdram_resp_bank #(
      .ROW_AW(ROW_AW),
      .TRCD  (TRCD)
    ) u_bank (
      .clk,
      .reset_n,
      .act     (is_act & sel[i]),
      .pre     (is_pre & (sd_addr[10] | sel[i])),
      .acc     (acc_ok & sel[i]),
      .auto_pre(sd_addr[10]),
      .row_in  (sd_addr[ROW_AW-1:0]),
      .opened  (opened[i]),
      .row     (row[i])
`ifdef SDRAM_RESP_CHECK_EN
      ,
      .early   (early[i])
`endif
    );
  end

  // mode register: only a LOAD_MODE with all banks idle counts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_ok <= 1'b0;
      cl3     <= 1'b0;
    end else if (is_lmr && all_idle) begin
      mode_ok <= mode_vld;
      if (mode_vld) cl3 <= sd_addr[MODE_CL_LO];
    end
  end

  // refresh counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      refresh_cnt <= '0;
    else if (is_ref && all_idle)
      refresh_cnt <= refresh_cnt + 16'd1;
  end

  logic [15:0]       mem [0:(1<<MEM_AW)-1];
  logic [MEM_AW-1:0] maddr;
  logic [15:0]       rd_data;

  assign maddr = {sd_ba, row[sd_ba], sd_addr[7:0]};

  // BRAM: byte-lane write, registered read every cycle
  always_ff @(posedge clk) begin
    if (is_wr && acc_ok) begin
      if (!sd_dqm[0]) mem[maddr][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqm[1]) mem[maddr][15:8] <= sd_dq_in[15:8];
    end
    rd_data <= mem[maddr];
  end

  logic        s0_v, s0_late, s1_v;
  logic [15:0] s1_d;
  logic [1:0]  dqm_q;

  // read pipe: rd_data/s0 then s1, output stage masked by DQM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_v      <= 1'b0;
      s0_late   <= 1'b0;
      s1_v      <= 1'b0;
      s1_d      <= '0;
      dqm_q     <= '0;
      sd_dq_oe  <= 1'b0;
      sd_dq_out <= '0;
    end else begin
      dqm_q   <= sd_dqm;
      s0_v    <= is_rd & acc_ok;
      s0_late <= cl3;
      s1_v    <= s0_v & s0_late & ~cancel;
      s1_d    <= rd_data;
      if (!cancel && s0_v && !s0_late) begin
        sd_dq_oe  <= 1'b1;
        sd_dq_out <= rd_data &
          {{8{~dqm_q[1]}}, {8{~dqm_q[0]}}};
      end else if (!cancel && s1_v) begin
        sd_dq_oe  <= 1'b1;
        sd_dq_out <= s1_d &
          {{8{~dqm_q[1]}}, {8{~dqm_q[0]}}};
      end else begin
        sd_dq_oe  <= 1'b0;
        sd_dq_out <= '0;
      end
    end
  end

`ifdef SDRAM_RESP_CHECK_EN
  // protocol violations seen this cycle
  always_comb begin
    err_set = '0;
    err_set[ERR_TRCD] = acc_ok & early[sd_ba];
    err_set[ERR_BANK] =
      (is_act & sel_open) |
      ((is_rd | is_wr) & ~sel_open) |
      ((is_lmr | is_ref) & ~all_idle);
    err_set[ERR_MODE]   = is_lmr & all_idle & ~mode_vld;
    err_set[ERR_NOMODE] = (is_rd | is_wr) & ~mode_ok;
  end

  // sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= '0;
    else          err <= err | err_set;
  end
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed + random commands checked against
// a behavioural SDRAM model kept in the bench.
`timescale 1ns/1ps
module tb_sdram_responder;
  import sdram_resp_pkg::*;

  localparam int TRCD = 2;
`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_cs = 1'b1;
  logic        sd_ras = 1'b1;
  logic        sd_cas = 1'b1;
  logic        sd_we = 1'b1;
  logic [1:0]  sd_ba = '0;
  logic [12:0] sd_addr = '0;
  logic [1:0]  sd_dqm = '0;
  logic [15:0] sd_dq_in = '0;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic        mode_ok;
  logic [15:0] refresh_cnt;
  logic [3:0]  err;

  always #5 clk = ~clk;

  sdram_responder #(.ROW_AW(4), .TRCD(TRCD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sd_cs      (sd_cs),
    .sd_ras     (sd_ras),
    .sd_cas     (sd_cas),
    .sd_we      (sd_we),
    .sd_ba      (sd_ba),
    .sd_addr    (sd_addr),
    .sd_dqm     (sd_dqm),
    .sd_dq_in   (sd_dq_in),
    .sd_dq_out  (sd_dq_out),
    .sd_dq_oe   (sd_dq_oe),
    .mode_ok    (mode_ok),
    .refresh_cnt(refresh_cnt),
    .err        (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          out_edge;
    logic [15:0] data;
    logic [1:0]  kn;
  } rd_t;

  logic [15:0] mm [16384];
  bit   [1:0]  kn [16384];
  bit          m_open [4];
  int          m_row [4];
  int          m_act [4];
  bit          m_mode;
  int          m_cl;
  int          m_ref;
  logic [3:0]  m_err;
  logic [1:0]  m_dqm_prev;
  rd_t         pend [$];
  int          edge_n = 0;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
    m_mode = 1'b0;
    m_cl = 2;
    m_ref = 0;
    m_err = '0;
    m_dqm_prev = '0;
    pend.delete();
  endtask

  task automatic cmd(input logic [3:0]  c,
                     input logic [1:0]  ba,
                     input logic [12:0] a,
                     input logic [1:0]  dqm,
                     input logic [15:0] dq);
    logic        e_oe;
    logic [15:0] e_dq, km;
    bit          bad, any_open;
    int          idx;
    rd_t         r;
    @(negedge clk);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba = ba;
    sd_addr = a;
    sd_dqm = dqm;
    sd_dq_in = dq;
    @(posedge clk);
    edge_n++;
    if (c == CMD_WRITE || c == CMD_BST) pend.delete();
    e_oe = 1'b0;
    e_dq = '0;
    km = 16'hFFFF;
    for (int i = 0; i < pend.size(); i++)
      if (pend[i].out_edge == edge_n) begin
        e_oe = 1'b1;
        for (int l = 0; l < 2; l++)
          if (!m_dqm_prev[l]) begin
            e_dq[l*8 +: 8] = pend[i].data[l*8 +: 8];
            if (!pend[i].kn[l]) km[l*8 +: 8] = 8'h00;
          end
      end
    pend = pend.find with (item.out_edge > edge_n);
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    idx = int'(ba) * 4096 + m_row[ba] * 256 + int'(a[7:0]);
    case (c)
      CMD_ACT:
        if (m_open[ba]) m_err[1] = 1'b1;
        else begin
          m_open[ba] = 1'b1;
          m_row[ba] = int'(a[3:0]);
          m_act[ba] = edge_n;
        end
      CMD_READ, CMD_WRITE: begin
        bad = 1'b0;
        if (!m_mode) begin m_err[3] = 1'b1; bad = 1'b1; end
        if (!m_open[ba]) begin m_err[1] = 1'b1; bad = 1'b1; end
        if (!bad) begin
          if (edge_n - m_act[ba] < TRCD) m_err[0] = 1'b1;
          if (c == CMD_WRITE) begin
            for (int l = 0; l < 2; l++)
              if (!dqm[l]) begin
                mm[idx][l*8 +: 8] = dq[l*8 +: 8];
                kn[idx][l] = 1'b1;
              end
          end else begin
            r.out_edge = edge_n + m_cl - 1;
            r.data = mm[idx];
            r.kn = kn[idx];
            pend.push_back(r);
          end
          if (a[10]) m_open[ba] = 1'b0;
        end
      end
      CMD_PRE:
        if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
        else m_open[ba] = 1'b0;
      CMD_REF:
        if (any_open) m_err[1] = 1'b1;
        else m_ref = (m_ref + 1) & 16'hFFFF;
      CMD_LMR:
        if (any_open) m_err[1] = 1'b1;
        else if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) &&
                 a[2:0] == 3'b000 && a[9]) begin
          m_mode = 1'b1;
          m_cl = int'(a[6:4]);
        end else begin
          m_err[2] = 1'b1;
          m_mode = 1'b0;
        end
      default: ;
    endcase
    m_dqm_prev = dqm;
    #1;
    check("oe", 32'(sd_dq_oe), 32'(e_oe));
    check("dq", 32'(sd_dq_out & km), 32'(e_dq & km));
    check("mode_ok", 32'(mode_ok), 32'(m_mode));
    check("refresh", 32'(refresh_cnt), 32'(m_ref));
    check("err", 32'(err), 32'(CHK ? m_err : 4'h0));
  endtask

  task automatic nop();
    cmd(CMD_NOP, 2'd0, 13'd0, 2'b00, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {sd_cs, sd_ras, sd_cas, sd_we} = 4'b1111;
    sd_dqm = 2'b00;
    #2 reset_n = 1'b0;
    #1;
    check("rst_oe", 32'(sd_dq_oe), 32'd0);
    check("rst_dq", 32'(sd_dq_out), 32'd0);
    check("rst_mode", 32'(mode_ok), 32'd0);
    check("rst_ref", 32'(refresh_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [12:0] a;
    logic [1:0]  ba, dqm;
    logic [15:0] dq;
    int          r;

    model_reset();
    do_reset();

    cmd(CMD_LMR, 2'd0, 13'h220, 2'b00, 16'd0);
    check("lmr_cl2_ok", 32'(mode_ok), 32'd1);
    check("lmr_err0", 32'(err), 32'd0);

    cmd(CMD_ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop();
    cmd(CMD_WRITE, 2'd1, 13'h410, 2'b00, 16'hBEEF);
    cmd(CMD_ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop();
    cmd(CMD_READ, 2'd1, 13'h410, 2'b00, 16'd0);
    nop();
    check("rd_oe", 32'(sd_dq_oe), 32'd1);
    check("rd_beef", 32'(sd_dq_out), 32'hBEEF);
    nop();
    check("rd_oe_off", 32'(sd_dq_oe), 32'd0);

    cmd(CMD_ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop();
    cmd(CMD_WRITE, 2'd1, 13'h010, 2'b10, 16'h1234);
    cmd(CMD_READ, 2'd1, 13'h010, 2'b00, 16'd0);
    cmd(CMD_READ, 2'd1, 13'h010, 2'b01, 16'd0);
    check("rd_merge", 32'(sd_dq_out), 32'hBE34);
    nop();
    check("rd_dqm_oe", 32'(sd_dq_oe), 32'd1);
    check("rd_dqm", 32'(sd_dq_out), 32'hBE00);
    cmd(CMD_PRE, 2'd0, 13'h400, 2'b00, 16'd0);

    cmd(CMD_LMR, 2'd0, 13'h230, 2'b00, 16'd0);
    cmd(CMD_ACT, 2'd1, 13'd5, 2'b00, 16'd0);
    nop();
    nop();
    cmd(CMD_READ, 2'd1, 13'h010, 2'b00, 16'd0);
    nop();
    check("cl3_early", 32'(sd_dq_oe), 32'd0);
    nop();
    check("cl3_oe", 32'(sd_dq_oe), 32'd1);
    check("cl3_data", 32'(sd_dq_out), 32'hBE34);
    nop();
    check("cl3_off", 32'(sd_dq_oe), 32'd0);

    cmd(CMD_READ, 2'd1, 13'h010, 2'b00, 16'd0);
    cmd(CMD_NOP, 2'd0, 13'd0, 2'b11, 16'd0);
    nop();
    check("cl3_dqm_oe", 32'(sd_dq_oe), 32'd1);
    check("cl3_dqm", 32'(sd_dq_out), 32'h0000);

    cmd(CMD_READ, 2'd1, 13'h010, 2'b00, 16'd0);
    cmd(CMD_WRITE, 2'd1, 13'h020, 2'b00, 16'h5555);
    nop();
    check("cancel_oe1", 32'(sd_dq_oe), 32'd0);
    nop();
    check("cancel_oe2", 32'(sd_dq_oe), 32'd0);
    cmd(CMD_PRE, 2'd0, 13'h400, 2'b00, 16'd0);

    cmd(CMD_ACT, 2'd0, 13'd1, 2'b00, 16'd0);
    cmd(CMD_READ, 2'd0, 13'h000, 2'b00, 16'd0);
    check("trcd_err", 32'(err[0]), 32'(CHK));
    cmd(CMD_PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    nop();
    nop();
    cmd(CMD_READ, 2'd3, 13'h000, 2'b00, 16'd0);
    check("idle_err", 32'(err[1]), 32'(CHK));
    nop();
    nop();
    nop();
    check("idle_oe", 32'(sd_dq_oe), 32'd0);

    do_reset();
    cmd(CMD_LMR, 2'd0, 13'h220, 2'b00, 16'd0);
    for (int i = 0; i < 3; i++)
      cmd(CMD_REF, 2'd0, 13'd0, 2'b00, 16'd0);
    check("ref3", 32'(refresh_cnt), 32'd3);
    cmd(CMD_ACT, 2'd2, 13'd0, 2'b00, 16'd0);
    cmd(CMD_REF, 2'd0, 13'd0, 2'b00, 16'd0);
    check("ref_open", 32'(refresh_cnt), 32'd3);
    check("ref_err", 32'(err[1]), 32'(CHK));
    do_reset();

    cmd(CMD_LMR, 2'd0, 13'h220, 2'b00, 16'd0);
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) begin
        do_reset();
        cmd(CMD_LMR, 2'd0, 13'h220, 2'b00, 16'd0);
      end
      r   = int'($urandom_range(0, 99));
      ba  = 2'($urandom);
      a   = 13'($urandom);
      dqm = 2'($urandom);
      dq  = 16'($urandom);
      a[7:0] = 8'($urandom_range(0, 15));
      if (r < 4) begin
        case ($urandom_range(0, 2))
          0: a = 13'h220;
          1: a = 13'h230;
          default: a = 13'($urandom);
        endcase
        cmd(CMD_LMR, ba, a, dqm, dq);
      end else if (r < 8)
        cmd(CMD_REF, ba, a, dqm, dq);
      else if (r < 12)
        cmd(CMD_BST, ba, a, dqm, dq);
      else if (r < 20)
        cmd(CMD_PRE, ba, a, dqm, dq);
      else if (r < 40) begin
        a[3:0] = 4'($urandom_range(0, 3));
        cmd(CMD_ACT, ba, a, dqm, dq);
      end else if (r < 65)
        cmd(CMD_READ, ba, a, dqm, dq);
      else if (r < 85)
        cmd(CMD_WRITE, ba, a, dqm, dq);
      else if (r < 95)
        cmd(CMD_NOP, ba, a, dqm, dq);
      else
        cmd(4'b1000 | 4'($urandom_range(0, 7)), ba, a, dqm, dq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
